// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG result write-back DMA.
// The completion interrupt is built only when JPEG_RESULT_DMA_IRQ_EN is defined.
package jpeg_pkg;

  localparam int BLK_WORDS = 32;
  localparam int IDX_W     = 5;

  localparam logic [1:0] REG_DST   = 2'd0;
  localparam logic [1:0] REG_COUNT = 2'd1;
  localparam logic [1:0] REG_CTRL  = 2'd2;
  localparam logic [1:0] REG_RSVD  = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CLEAR = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BLK,
    ST_RD,
    ST_WR,
    ST_NEXT,
    ST_ERR
  } dma_state_e;

  typedef struct packed {
    dma_state_e       state;
    logic [IDX_W-1:0] idx;
    logic [15:0]      remaining;
    logic             pending;
    logic             abort_req;
  } dma_dbg_t;

endpackage

// File: rtl/jpeg_result_regs.sv
// Slave register window of the result DMA: DST/COUNT storage, CTRL command
// pulses and the combinational read mux.
module jpeg_result_regs
  import jpeg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        regen_i,
  input  logic [1:0]  adr_i,
  input  logic [31:0] dat_i,
  input  logic        we_i,
  input  logic        busy_i,
  input  logic        done_i,
  input  logic        err_i,
  input  logic [15:0] remaining_i,
  output logic [31:0] dat_o,
  output logic [31:0] dst_o,
  output logic [15:0] count_o,
  output logic        start_o,
  output logic        abort_o,
  output logic        clear_o
);

  logic        wr_en;
  logic        wr_ctrl;
  logic [31:0] dst_q;
  logic [15:0] count_q;

  assign wr_en   = regen_i && we_i;
  assign wr_ctrl = wr_en && (adr_i == REG_CTRL);

  // Start is only meaningful while idle; abort and clear act in any state.
  assign start_o = wr_ctrl && dat_i[CTRL_START] && !busy_i;
  assign abort_o = wr_ctrl && dat_i[CTRL_ABORT];
  assign clear_o = wr_ctrl && dat_i[CTRL_CLEAR];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dst_q   <= '0;
      count_q <= '0;
    end else if (wr_en && !busy_i) begin
      if (adr_i == REG_DST)   dst_q   <= {dat_i[31:2], 2'b00};
      if (adr_i == REG_COUNT) count_q <= dat_i[15:0];
    end
  end

  always_comb begin
    dat_o = '0;
    case (adr_i)
      REG_DST:   dat_o = dst_q;
      REG_COUNT: dat_o = {16'd0, count_q};
      REG_CTRL: begin
        dat_o[STAT_BUSY] = busy_i;
        dat_o[STAT_DONE] = done_i;
        dat_o[STAT_ERR]  = err_i;
        dat_o[31:16]     = remaining_i;
      end
      default:   dat_o = '0;
    endcase
  end

  assign dst_o   = dst_q;
  assign count_o = count_q;

endmodule

// File: rtl/jpeg_result_dma.sv
// Result write-back DMA: copies each finished 8x8 coefficient block from the
// DCT output RAM to memory with Wishbone single writes. irq_o: JPEG_RESULT_DMA_IRQ_EN.
module jpeg_result_dma
  import jpeg_pkg::*;
#(
  parameter int BLK_WORDS = jpeg_pkg::BLK_WORDS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        regen_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  output logic [31:0] wb_dat_o,
  output logic [4:0]  ures_addr_o,
  input  logic [31:0] ures_data_i,
  input  logic        block_ready_i,
  output logic        block_free_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
`ifdef JPEG_RESULT_DMA_IRQ_EN
  output logic        irq_o,
`endif
  output dma_dbg_t    dbg_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_WORDS - 1);

  dma_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      addr_q;
  logic [15:0]      remaining_q;
  logic             pending_q, abort_q, done_q, err_q;

  logic [31:0] dst;
  logic [15:0] count;
  logic        start, abort, clear;
  logic        busy, blk_go, word_ack, err_enter, done_set;
  logic        adr_unused;

  jpeg_result_regs u_regs (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .regen_i     (regen_i),
    .adr_i       (wb_adr_i[3:2]),
    .dat_i       (wb_dat_i),
    .we_i        (wb_we_i),
    .busy_i      (busy),
    .done_i      (done_q),
    .err_i       (err_q),
    .remaining_i (remaining_q),
    .dat_o       (wb_dat_o),
    .dst_o       (dst),
    .count_o     (count),
    .start_o     (start),
    .abort_o     (abort),
    .clear_o     (clear)
  );

  assign adr_unused = ^{wb_adr_i[31:4], wb_adr_i[1:0]};

  assign busy      = (state_q != ST_IDLE);
  assign blk_go    = (state_q == ST_WAIT_BLK) && !abort && (block_ready_i || pending_q);
  assign err_enter = (state_q == ST_WR) && wbm_err_i;
  assign word_ack  = (state_q == ST_WR) && wbm_ack_i && !wbm_err_i;
  assign done_set  = (start && count == 16'd0) ||
                     (state_q == ST_NEXT && remaining_q == 16'd0 && !abort);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start && count != 16'd0) state_d = ST_WAIT_BLK;
      ST_WAIT_BLK: begin
        if (abort)                            state_d = ST_IDLE;
        else if (block_ready_i || pending_q)  state_d = ST_RD;
      end
      ST_RD:       state_d = abort ? ST_IDLE : ST_WR;
      ST_WR: begin
        // err wins over a simultaneous ack; a requested abort waits for the response
        if (wbm_err_i)                 state_d = ST_ERR;
        else if (wbm_ack_i) begin
          if (abort_q || abort)        state_d = ST_IDLE;
          else if (idx_q == LAST_IDX)  state_d = ST_NEXT;
          else                         state_d = ST_RD;
        end
      end
      ST_NEXT:     state_d = (abort || remaining_q == 16'd0) ? ST_IDLE : ST_WAIT_BLK;
      ST_ERR:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Wishbone master handshake: cyc spans the whole block; in WR, stb/we/sel,
  // address and data are held stable until ack or err, one word per response.
  always_comb begin
    wbm_cyc_o = (state_q == ST_RD) || (state_q == ST_WR);
    wbm_stb_o = (state_q == ST_WR);
    wbm_we_o  = (state_q == ST_WR);
    wbm_sel_o = (state_q == ST_WR) ? 4'hF : 4'h0;
    wbm_dat_o = (state_q == ST_WR) ? ures_data_i : 32'd0;
  end

  assign wbm_adr_o    = addr_q;
  assign ures_addr_o  = idx_q;
  assign block_free_o = (state_q == ST_IDLE) || (state_q == ST_WAIT_BLK);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      pending_q   <= 1'b0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;

      if (start) begin
        addr_q      <= dst;
        remaining_q <= count;
      end else if (word_ack) begin
        addr_q <= addr_q + 32'd4;
        if (idx_q == LAST_IDX) remaining_q <= remaining_q - 16'd1;
      end

      if (blk_go)                               idx_q <= '0;
      else if (word_ack && idx_q != LAST_IDX)   idx_q <= idx_q + 1'b1;

      // A stale pending block never survives a return to idle.
      if (state_d == ST_IDLE || blk_go)
        pending_q <= 1'b0;
      else if (block_ready_i &&
               (state_q == ST_RD || state_q == ST_WR || state_q == ST_NEXT))
        pending_q <= 1'b1;

      abort_q <= (state_q == ST_WR) && (state_d == ST_WR) && (abort_q || abort);

      if (clear || start) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (done_set)  done_q <= 1'b1;
      if (err_enter) err_q  <= 1'b1;
    end
  end

`ifdef JPEG_RESULT_DMA_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                       irq_q <= 1'b0;
    else if (done_set || err_enter)  irq_q <= 1'b1;
    else if (clear)                  irq_q <= 1'b0;
  end

  assign irq_o = irq_q;
`endif

  assign dbg_o = '{state: state_q, idx: idx_q, remaining: remaining_q,
                   pending: pending_q, abort_req: abort_q};

endmodule

// File: tb/tb_jpeg_result_dma.sv
// Directed self-checking bench for jpeg_result_dma: output-RAM model, Wishbone
// slave with programmable ack delay / error injection, and a write scoreboard.
module tb_jpeg_result_dma;
  import jpeg_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        regen = 1'b0;
  logic [31:0] wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic        wb_we = 1'b0;
  logic [31:0] wb_rdata;
  logic [4:0]  ures_addr;
  logic [31:0] ures_data = '0;
  logic        block_ready = 1'b0;
  logic        block_free;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
`ifdef JPEG_RESULT_DMA_IRQ_EN
  logic        irq;
`endif
  dma_dbg_t    dbg;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] sb_exp;
  logic [31:0] mem [32];
  int          ack_delay = 0;
  int          err_word = -1;
  int          wait_cnt = 0;
  int          word_cnt = 0;
  int          write_cnt = 0;

  always #5 clk = ~clk;

  jpeg_result_dma dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .regen_i       (regen),
    .wb_adr_i      (wb_adr),
    .wb_dat_i      (wb_dat),
    .wb_we_i       (wb_we),
    .wb_dat_o      (wb_rdata),
    .ures_addr_o   (ures_addr),
    .ures_data_i   (ures_data),
    .block_ready_i (block_ready),
    .block_free_o  (block_free),
    .wbm_adr_o     (wbm_adr_o),
    .wbm_dat_o     (wbm_dat_o),
    .wbm_sel_o     (wbm_sel_o),
    .wbm_cyc_o     (wbm_cyc_o),
    .wbm_stb_o     (wbm_stb_o),
    .wbm_we_o      (wbm_we_o),
    .wbm_ack_i     (wbm_ack_i),
    .wbm_err_i     (wbm_err_i),
`ifdef JPEG_RESULT_DMA_IRQ_EN
    .irq_o         (irq),
`endif
    .dbg_o         (dbg)
  );

  // Output RAM model: one cycle read latency
  always @(posedge clk) ures_data <= mem[ures_addr];

  // Wishbone slave + scoreboard; responds 1 time unit after the edge
  always begin
    @(posedge clk);
    #1;
    if (wbm_ack_i || wbm_err_i) begin
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wait_cnt  = 0;
    end else if (wbm_cyc_o && wbm_stb_o) begin
      if (wait_cnt == ack_delay) begin
        wait_cnt = 0;
        if (word_cnt == err_word) begin
          wbm_err_i = 1'b1;
        end else begin
          wbm_ack_i = 1'b1;
          write_cnt++;
          total_cnt++;
          if (exp_q.size() == 0) begin
            $display("FAIL sb_write: unexpected write adr=%h dat=%h", wbm_adr_o, wbm_dat_o);
          end else begin
            sb_exp = exp_q.pop_front();
            if ({wbm_adr_o, wbm_dat_o} !== sb_exp || wbm_sel_o !== 4'hF || wbm_we_o !== 1'b1)
              $display("FAIL sb_write: got adr=%h dat=%h sel=%h we=%b want adr=%h dat=%h sel=f we=1",
                       wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, sb_exp[63:32], sb_exp[31:0]);
            else
              pass_cnt++;
          end
        end
        word_cnt++;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reg_write(input logic [1:0] r, input logic [31:0] d);
    wb_adr = {28'd0, r, 2'b00};
    wb_dat = d;
    wb_we  = 1'b1;
    regen  = 1'b1;
    tick();
    regen  = 1'b0;
    wb_we  = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] r, output logic [31:0] d);
    wb_adr = {28'd0, r, 2'b00};
    wb_we  = 1'b0;
    regen  = 1'b1;
    #1;
    d      = wb_rdata;
    regen  = 1'b0;
  endtask

  task automatic pulse_ready();
    block_ready = 1'b1;
    tick();
    block_ready = 1'b0;
  endtask

  task automatic fill_mem(input logic [31:0] base);
    for (int i = 0; i < 32; i++) mem[i] = base + 32'(i);
  endtask

  task automatic push_words(input logic [31:0] a, input logic [31:0] base, input int nw);
    for (int i = 0; i < nw; i++) exp_q.push_back({a + 32'(4 * i), base + 32'(i % 32)});
  endtask

  task automatic wait_free(input int bound, output int n);
    n = 0;
    while (block_free !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(input int bound, output int n);
    logic [31:0] c;
    n = 0;
    reg_read(REG_CTRL, c);
    while (c[0] !== 1'b0 && n < bound) begin
      tick();
      n++;
      reg_read(REG_CTRL, c);
    end
  endtask

  task automatic test_reset();
    logic [31:0] c;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    total_cnt++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 3'b000) $display("FAIL reset_cyc_stb_we: got %b want 000", {wbm_cyc_o, wbm_stb_o, wbm_we_o}); else pass_cnt++;
    total_cnt++; if (wbm_sel_o !== 4'h0) $display("FAIL reset_sel: got %h want 0", wbm_sel_o); else pass_cnt++;
    total_cnt++; if (wbm_adr_o !== 32'h0) $display("FAIL reset_adr: got %h want 0", wbm_adr_o); else pass_cnt++;
    total_cnt++; if (ures_addr !== 5'd0) $display("FAIL reset_ures_addr: got %h want 0", ures_addr); else pass_cnt++;
    total_cnt++; if (block_free !== 1'b1) $display("FAIL reset_block_free: got %b want 1", block_free); else pass_cnt++;
    total_cnt++; if (dbg.state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg.state, ST_IDLE); else pass_cnt++;
    reg_read(REG_CTRL, c);
    total_cnt++; if (c !== 32'h0) $display("FAIL reset_ctrl: got %h want 0", c); else pass_cnt++;
`ifdef JPEG_RESULT_DMA_IRQ_EN
    total_cnt++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else pass_cnt++;
`endif
  endtask

  task automatic test_single();
    logic [31:0] c;
    int n, cyc_cnt, w0;
    ack_delay = 0;
    fill_mem(32'h0);
    reg_write(REG_DST, 32'h1000);
    reg_write(REG_COUNT, 32'd1);
    push_words(32'h1000, 32'h0, 32);
    w0 = write_cnt;
    reg_write(REG_CTRL, 32'h1);
    total_cnt++; if (block_free !== 1'b1 || wbm_cyc_o !== 1'b0) $display("FAIL single_wait: got free=%b cyc=%b want free=1 cyc=0", block_free, wbm_cyc_o); else pass_cnt++;
    pulse_ready();
    total_cnt++; if (wbm_cyc_o !== 1'b1) $display("FAIL single_cyc_rise: got %b want 1", wbm_cyc_o); else pass_cnt++;
    n = 0;
    cyc_cnt = 1;
    while (block_free !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (wbm_cyc_o === 1'b1) cyc_cnt++;
    end
    total_cnt++; if (n !== 65) $display("FAIL single_latency: got %0d want 65", n); else pass_cnt++;
    total_cnt++; if (cyc_cnt !== 64) $display("FAIL single_cyc_span: got %0d want 64", cyc_cnt); else pass_cnt++;
    reg_read(REG_CTRL, c);
    total_cnt++; if (c !== 32'h0000_0002) $display("FAIL single_ctrl: got %h want 00000002", c); else pass_cnt++;
    total_cnt++; if (write_cnt - w0 !== 32 || exp_q.size() !== 0) $display("FAIL single_count: got %0d writes %0d left want 32 writes 0 left", write_cnt - w0, exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_multi();
    logic [31:0] c, want;
    int n, w0;
    ack_delay = 2;
    fill_mem(32'hB000_0000);
    reg_write(REG_DST, 32'h2000);
    reg_write(REG_COUNT, 32'd3);
    push_words(32'h2000, 32'hB000_0000, 96);
    w0 = write_cnt;
    reg_write(REG_CTRL, 32'h1);
    for (int b = 0; b < 3; b++) begin
      pulse_ready();
      wait_free(400, n);
      total_cnt++; if (n >= 400) $display("FAIL multi_timeout: block %0d got %0d cycles want <400", b, n); else pass_cnt++;
      want = (b == 2) ? 32'h0000_0002 : {16'(2 - b), 16'h0001};
      reg_read(REG_CTRL, c);
      total_cnt++; if (c !== want) $display("FAIL multi_ctrl: block %0d got %h want %h", b, c, want); else pass_cnt++;
    end
    total_cnt++; if (write_cnt - w0 !== 96 || exp_q.size() !== 0) $display("FAIL multi_count: got %0d writes %0d left want 96 writes 0 left", write_cnt - w0, exp_q.size()); else pass_cnt++;
    total_cnt++; if (wbm_adr_o !== 32'h2180) $display("FAIL multi_end_adr: got %h want 00002180", wbm_adr_o); else pass_cnt++;
    ack_delay = 0;
  endtask

  task automatic test_pending();
    logic [31:0] c;
    int n, w0;
    fill_mem(32'hC000_0000);
    reg_write(REG_DST, 32'h3000);
    reg_write(REG_COUNT, 32'd2);
    push_words(32'h3000, 32'hC000_0000, 64);
    w0 = write_cnt;
    reg_write(REG_CTRL, 32'h1);
    pulse_ready();
    repeat (10) tick();
    pulse_ready();
    wait_idle(300, n);
    total_cnt++; if (n >= 300) $display("FAIL pending_timeout: got %0d cycles want <300", n); else pass_cnt++;
    reg_read(REG_CTRL, c);
    total_cnt++; if (c !== 32'h0000_0002) $display("FAIL pending_ctrl: got %h want 00000002", c); else pass_cnt++;
    total_cnt++; if (write_cnt - w0 !== 64 || exp_q.size() !== 0) $display("FAIL pending_count: got %0d writes %0d left want 64 writes 0 left", write_cnt - w0, exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_err();
    logic [31:0] c;
    int n, w0;
    fill_mem(32'hD000_0000);
    reg_write(REG_DST, 32'h4000);
    reg_write(REG_COUNT, 32'd1);
    push_words(32'h4000, 32'hD000_0000, 5);
    w0 = write_cnt;
    err_word = word_cnt + 5;
    reg_write(REG_CTRL, 32'h1);
    pulse_ready();
    n = 0;
    while (wbm_cyc_o === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total_cnt++; if (n >= 100) $display("FAIL err_cyc_drop: got cyc=%b want 0", wbm_cyc_o); else pass_cnt++;
    total_cnt++; if (wbm_stb_o !== 1'b0 || block_free !== 1'b0) $display("FAIL err_state: got stb=%b free=%b want stb=0 free=0", wbm_stb_o, block_free); else pass_cnt++;
    total_cnt++; if (write_cnt - w0 !== 5 || exp_q.size() !== 0) $display("FAIL err_count: got %0d writes %0d left want 5 writes 0 left", write_cnt - w0, exp_q.size()); else pass_cnt++;
    tick();
    reg_read(REG_CTRL, c);
    total_cnt++; if (c !== 32'h0001_0004) $display("FAIL err_ctrl: got %h want 00010004", c); else pass_cnt++;
`ifdef JPEG_RESULT_DMA_IRQ_EN
    total_cnt++; if (irq !== 1'b1) $display("FAIL err_irq: got %b want 1", irq); else pass_cnt++;
`endif
    repeat (5) tick();
    total_cnt++; if (write_cnt - w0 !== 5 || wbm_cyc_o !== 1'b0) $display("FAIL err_quiet: got %0d writes cyc=%b want 5 writes cyc=0", write_cnt - w0, wbm_cyc_o); else pass_cnt++;
    reg_write(REG_CTRL, 32'h4);
    reg_read(REG_CTRL, c);
    total_cnt++; if (c !== 32'h0001_0000) $display("FAIL err_clear: got %h want 00010000", c); else pass_cnt++;
`ifdef JPEG_RESULT_DMA_IRQ_EN
    total_cnt++; if (irq !== 1'b0) $display("FAIL err_irq_clear: got %b want 0", irq); else pass_cnt++;
`endif
    err_word = -1;
  endtask

  task automatic test_abort();
    logic [31:0] c;
    int n, w0;
    ack_delay = 4;
    fill_mem(32'hE000_0000);
    reg_write(REG_DST, 32'h5000);
    reg_write(REG_COUNT, 32'd2);
    push_words(32'h5000, 32'hE000_0000, 1);
    w0 = write_cnt;
    reg_write(REG_CTRL, 32'h1);
    pulse_ready();
    n = 0;
    while (wbm_stb_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total_cnt++; if (n >= 20) $display("FAIL abort_reach_wr: got stb=%b want 1", wbm_stb_o); else pass_cnt++;
    reg_write(REG_CTRL, 32'h2);
    total_cnt++; if (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b1) $display("FAIL abort_holds_wr: got cyc=%b stb=%b want 1 1", wbm_cyc_o, wbm_stb_o); else pass_cnt++;
    wait_idle(50, n);
    reg_read(REG_CTRL, c);
    total_cnt++; if (c !== 32'h0002_0000) $display("FAIL abort_ctrl: got %h want 00020000", c); else pass_cnt++;
    total_cnt++; if (write_cnt - w0 !== 1 || exp_q.size() !== 0) $display("FAIL abort_count: got %0d writes %0d left want 1 write 0 left", write_cnt - w0, exp_q.size()); else pass_cnt++;
    ack_delay = 0;
    reg_write(REG_DST, 32'h6000);
    reg_write(REG_COUNT, 32'd1);
    push_words(32'h6000, 32'hE000_0000, 32);
    reg_write(REG_CTRL, 32'h1);
    pulse_ready();
    wait_idle(200, n);
    reg_read(REG_CTRL, c);
    total_cnt++; if (c !== 32'h0000_0002 || exp_q.size() !== 0) $display("FAIL abort_restart: got ctrl=%h left=%0d want 00000002 0", c, exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_count0_busy();
    logic [31:0] c;
    int n, w0;
    reg_write(REG_CTRL, 32'h4);
    reg_write(REG_COUNT, 32'd0);
    w0 = write_cnt;
    reg_write(REG_CTRL, 32'h1);
    reg_read(REG_CTRL, c);
    total_cnt++; if (c !== 32'h0000_0002) $display("FAIL count0_ctrl: got %h want 00000002", c); else pass_cnt++;
    total_cnt++; if (wbm_cyc_o !== 1'b0 || write_cnt !== w0) $display("FAIL count0_bus: got cyc=%b writes=%0d want 0 0", wbm_cyc_o, write_cnt - w0); else pass_cnt++;
`ifdef JPEG_RESULT_DMA_IRQ_EN
    total_cnt++; if (irq !== 1'b1) $display("FAIL count0_irq: got %b want 1", irq); else pass_cnt++;
`endif
    fill_mem(32'hF000_0000);
    reg_write(REG_DST, 32'h7000);
    reg_write(REG_COUNT, 32'd1);
    push_words(32'h7000, 32'hF000_0000, 32);
    reg_write(REG_CTRL, 32'h1);
    reg_write(REG_DST, 32'h9000);
    reg_write(REG_COUNT, 32'd5);
    pulse_ready();
    wait_idle(200, n);
    reg_read(REG_CTRL, c);
    total_cnt++; if (c !== 32'h0000_0002 || exp_q.size() !== 0) $display("FAIL busy_dst_ignored: got ctrl=%h left=%0d want 00000002 0", c, exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] c;
    int n, w0;
    ack_delay = 30;
    reg_write(REG_DST, 32'hA000);
    reg_write(REG_COUNT, 32'd1);
    w0 = write_cnt;
    reg_write(REG_CTRL, 32'h1);
    pulse_ready();
    n = 0;
    while (wbm_stb_o !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    rst = 1'b1;
    tick();
    total_cnt++; if ({wbm_cyc_o, wbm_stb_o, block_free} !== 3'b001) $display("FAIL reset_mid_bus: got cyc/stb/free=%b want 001", {wbm_cyc_o, wbm_stb_o, block_free}); else pass_cnt++;
    rst = 1'b0;
    tick();
    reg_read(REG_CTRL, c);
    total_cnt++; if (c !== 32'h0 || write_cnt !== w0) $display("FAIL reset_mid_ctrl: got ctrl=%h writes=%0d want 0 0", c, write_cnt - w0); else pass_cnt++;
    ack_delay = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_pending();
    test_err();
    test_abort();
    test_count0_busy();
    test_reset_mid();
    repeat (2) tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
